// File: rtl/hack_alu_pkg.sv
// Shared types and canonical opcodes for the Hack-style ALU.
// Opcode bit order is {zx, nx, zy, ny, f, no}, matching alu_ctrl_t.
package hack_alu_pkg;

    localparam int HACK_ALU_W = 16;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam logic [5:0] OP_ZERO  = 6'b101010;
    localparam logic [5:0] OP_ONE   = 6'b111111;
    localparam logic [5:0] OP_NEG1  = 6'b111010;
    localparam logic [5:0] OP_X     = 6'b001100;
    localparam logic [5:0] OP_Y     = 6'b110000;
    localparam logic [5:0] OP_NOTX  = 6'b001101;
    localparam logic [5:0] OP_NOTY  = 6'b110001;
    localparam logic [5:0] OP_NEGX  = 6'b001111;
    localparam logic [5:0] OP_NEGY  = 6'b110011;
    localparam logic [5:0] OP_XINC  = 6'b011111;
    localparam logic [5:0] OP_YINC  = 6'b110111;
    localparam logic [5:0] OP_XDEC  = 6'b001110;
    localparam logic [5:0] OP_YDEC  = 6'b110010;
    localparam logic [5:0] OP_ADD   = 6'b000010;
    localparam logic [5:0] OP_XSUBY = 6'b010011;
    localparam logic [5:0] OP_YSUBX = 6'b000111;
    localparam logic [5:0] OP_AND   = 6'b000000;
    localparam logic [5:0] OP_OR    = 6'b010101;

    function automatic alu_ctrl_t op2ctrl(input logic [5:0] op);
        return alu_ctrl_t'(op);
    endfunction

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU datapath: operand conditioning, add/and, output invert, flags.
// ALU_FLAGS_EXT_EN adds carry-out and signed-overflow outputs taken before the no inversion.
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = HACK_ALU_W
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  alu_ctrl_t        i_ctrl,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zr,
    output logic             o_ng
`ifdef ALU_FLAGS_EXT_EN
    ,
    output logic             o_cf,
    output logic             o_vf
`endif
);

    logic [WIDTH-1:0] w_xa, w_xb, w_ya, w_yb;
    logic [WIDTH-1:0] w_sum, w_r;

    assign w_xa = i_ctrl.zx ? '0 : i_x;
    assign w_xb = i_ctrl.nx ? ~w_xa : w_xa;
    assign w_ya = i_ctrl.zy ? '0 : i_y;
    assign w_yb = i_ctrl.ny ? ~w_ya : w_ya;

`ifdef ALU_FLAGS_EXT_EN
    logic w_cy;
    assign {w_cy, w_sum} = {1'b0, w_xb} + {1'b0, w_yb};
    // Both flags describe the adder, so they are forced low on the AND path.
    assign o_cf = i_ctrl.f & w_cy;
    assign o_vf = i_ctrl.f & (w_xb[WIDTH-1] == w_yb[WIDTH-1])
                           & (w_sum[WIDTH-1] != w_xb[WIDTH-1]);
`else
    assign w_sum = w_xb + w_yb;
`endif

    assign w_r   = i_ctrl.f ? w_sum : (w_xb & w_yb);
    assign o_res = i_ctrl.no ? ~w_r : w_r;
    assign o_zr  = (o_res == '0);
    assign o_ng  = o_res[WIDTH-1];

endmodule

// File: rtl/hack_alu.sv
// Hack ALU with a single registered result stage (latency 1, throughput 1/cycle).
// ALU_FLAGS_EXT_EN adds registered cf/vf ports.
module hack_alu
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = HACK_ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_FLAGS_EXT_EN
    ,
    output logic             cf,
    output logic             vf
`endif
);

    alu_ctrl_t        w_ctrl;
    logic [WIDTH-1:0] w_res;
    logic             w_zr, w_ng;
    logic [WIDTH-1:0] r_out;
    logic             r_zr, r_ng, r_valid;

    assign w_ctrl = op2ctrl({zx, nx, zy, ny, f, no});

`ifdef ALU_FLAGS_EXT_EN
    logic w_cf, w_vf;
    logic r_cf, r_vf;
`endif

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .i_x    (x),
        .i_y    (y),
        .i_ctrl (w_ctrl),
        .o_res  (w_res),
        .o_zr   (w_zr),
        .o_ng   (w_ng)
`ifdef ALU_FLAGS_EXT_EN
        ,
        .o_cf   (w_cf),
        .o_vf   (w_vf)
`endif
    );

    // Flags load in the same edge as the result, so they always describe r_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_zr    <= 1'b1;
            r_ng    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_res;
                r_zr  <= w_zr;
                r_ng  <= w_ng;
            end
        end
    end

`ifdef ALU_FLAGS_EXT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cf <= 1'b0;
            r_vf <= 1'b0;
        end else if (in_valid) begin
            r_cf <= w_cf;
            r_vf <= w_vf;
        end
    end

    assign cf = r_cf;
    assign vf = r_vf;
`endif

    assign out_valid = r_valid;
    assign out       = r_out;
    assign zr        = r_zr;
    assign ng        = r_ng;

endmodule

// File: tb/tb_hack_alu.sv
// Scoreboard bench for hack_alu: directed vectors push expected results,
// a negedge monitor pops and checks them exactly one cycle after issue.
module tb_hack_alu;
    import hack_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] x, y;
    logic        zx, nx, zy, ny, f, no;
    logic        out_valid;
    logic [15:0] out;
    logic        zr, ng;
`ifdef ALU_FLAGS_EXT_EN
    logic        cf, vf;
`endif

    hack_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .out_valid (out_valid),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
`ifdef ALU_FLAGS_EXT_EN
        ,
        .cf        (cf),
        .vf        (vf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        chk_ext;
        logic        cf;
        logic        vf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [15:0] vx, input logic [15:0] vy, input logic [5:0] op);
        x = vx;
        y = vy;
        {zx, nx, zy, ny, f, no} = op;
    endtask

    task automatic vec(input string name, input logic [15:0] vx, input logic [15:0] vy,
                       input logic [5:0] op, input logic [15:0] eout,
                       input logic chk = 1'b0, input logic ecf = 1'b0, input logic evf = 1'b0);
        exp_t e;
        @(negedge clk);
        drive(vx, vy, op);
        in_valid = 1'b1;
        e.name = name; e.out = eout; e.chk_ext = chk; e.cf = ecf; e.vf = evf; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // An item is due when the clock has advanced one edge past its issue cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                m_e = sb.pop_front();
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s: out_valid=%b at cycle %0d, want 1", m_e.name, out_valid, cyc);
                end else if (out !== m_e.out || zr !== (m_e.out == 16'h0) || ng !== m_e.out[15]
                             || cyc != m_e.cyc + 1) begin
                    n_err++;
                    $display("FAIL %s: got out=%h zr=%b ng=%b cyc=%0d, want out=%h zr=%b ng=%b cyc=%0d",
                             m_e.name, out, zr, ng, cyc, m_e.out, (m_e.out == 16'h0), m_e.out[15],
                             m_e.cyc + 1);
                end
`ifdef ALU_FLAGS_EXT_EN
                else if (m_e.chk_ext && (cf !== m_e.cf || vf !== m_e.vf)) begin
                    n_err++;
                    $display("FAIL %s_ext: got cf=%b vf=%b, want cf=%b vf=%b",
                             m_e.name, cf, vf, m_e.cf, m_e.vf);
                end
`endif
            end else if (out_valid === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: out_valid=1 at cycle %0d with nothing due", cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        drive(16'h0, 16'h0, OP_AND);
        repeat (2) @(negedge clk);
        check("rst_out", out, 16'h0000);
        check("rst_flags", {15'h0, zr}, 16'h0001);
        check("rst_ng", {15'h0, ng}, 16'h0000);
        check("rst_valid", {15'h0, out_valid}, 16'h0000);
`ifdef ALU_FLAGS_EXT_EN
        check("rst_cfvf", {14'h0, cf, vf}, 16'h0000);
`endif
        rst_n = 1'b1;

        // Asynchronous reset mid-stream while holding 0x0005.
        vec("pre_rst_add", 16'h0002, 16'h0003, OP_ADD, 16'h0005);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 16'h0000);
        check("async_rst_zr_ng_v", {13'h0, zr, ng, out_valid}, 16'h0004);
        @(negedge clk);
        rst_n = 1'b1;

        vec("zero",  16'h0002, 16'h0003, OP_ZERO,  16'h0000);
        vec("one",   16'h0002, 16'h0003, OP_ONE,   16'h0001);
        vec("neg1",  16'h0002, 16'h0003, OP_NEG1,  16'hFFFF);
        vec("x",     16'h0002, 16'h0003, OP_X,     16'h0002);
        vec("y",     16'h0002, 16'h0003, OP_Y,     16'h0003);
        vec("notx",  16'h0002, 16'h0003, OP_NOTX,  16'hFFFD);
        vec("noty",  16'h0002, 16'h0003, OP_NOTY,  16'hFFFC);
        vec("negx",  16'h0002, 16'h0003, OP_NEGX,  16'hFFFE);
        vec("negy",  16'h0002, 16'h0003, OP_NEGY,  16'hFFFD);
        vec("xinc",  16'h0002, 16'h0003, OP_XINC,  16'h0003);
        vec("yinc",  16'h0002, 16'h0003, OP_YINC,  16'h0004);
        vec("xdec",  16'h0002, 16'h0003, OP_XDEC,  16'h0001);
        vec("ydec",  16'h0002, 16'h0003, OP_YDEC,  16'h0002);
        vec("add",   16'h0002, 16'h0003, OP_ADD,   16'h0005);
        vec("xsuby", 16'h0002, 16'h0003, OP_XSUBY, 16'hFFFF);
        vec("ysubx", 16'h0002, 16'h0003, OP_YSUBX, 16'h0001);
        vec("and",   16'h0002, 16'h0003, OP_AND,   16'h0002);
        vec("or",    16'h0002, 16'h0003, OP_OR,    16'h0003);
        vec("ovf_add",  16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b1);
        vec("wrap_add", 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b1, 1'b0);
        vec("and_noext", 16'hFFFF, 16'hFFFF, OP_AND, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        vec("b2b_x",     16'h1234, 16'h0000, OP_X,     16'h1234);
        vec("b2b_negy",  16'h0000, 16'h0001, OP_NEGY,  16'hFFFF);
        vec("b2b_xsuby", 16'h0010, 16'h0003, OP_XSUBY, 16'h000D);
        idle();

        // Hold: valid drops, result and flags stay put; inputs change underneath.
        drive(16'hAAAA, 16'h5555, OP_ONE);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("hold_valid", {15'h0, out_valid}, 16'h0000);
            check("hold_out", out, 16'h000D);
            check("hold_zr_ng", {14'h0, zr, ng}, 16'h0000);
        end

        // In-flight op discarded by a reset spanning its capture edge.
        @(negedge clk);
        drive(16'h0002, 16'h0003, OP_ADD);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("discard_valid", {15'h0, out_valid}, 16'h0000);
        check("discard_out", out, 16'h0000);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results still pending, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
